// File: rtl/program_counter_pkg.sv
// Shared encodings for the ECO32 program-counter sequencing logic:
// PC source selects, instruction classes, exception causes and FSM states.
package program_counter_pkg;

  typedef enum logic [2:0] {
    PcSrcIncrement    = 3'd0,
    PcSrcAddImmediate = 3'd1,
    PcSrcAddOffset    = 3'd2,
    PcSrcExplicit     = 3'd3,
    PcSrcException    = 3'd4,
    PcSrcUserTlbMiss  = 3'd5
  } pc_source_e;

  typedef enum logic [2:0] {
    ClassOrdinary     = 3'd0,
    ClassBranch       = 3'd1,
    ClassJump         = 3'd2,
    ClassJumpRegister = 3'd3,
    ClassRfx          = 3'd4,
    ClassTrap         = 3'd5
  } instr_class_e;

  localparam logic [4:0] CauseBusTimeout      = 5'd16;
  localparam logic [4:0] CauseIllegalInstr    = 5'd17;
  localparam logic [4:0] CausePrivilegedInstr = 5'd18;
  localparam logic [4:0] CauseTrap            = 5'd20;
  localparam logic [4:0] CauseTlbMiss         = 5'd21;

  typedef enum logic [2:0] {
    StBoundary  = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StUpdate    = 3'd4,
    StException = 3'd5
  } state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles an instruction fetch has been outstanding; expired flags the
// last permitted request cycle. TimeoutCycles = 0 disables expiry.
module fetch_timeout_counter #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned Limit      = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam int unsigned CountWidth = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
  localparam logic [CountWidth-1:0] LimitValue = CountWidth'(Limit);

  logic [CountWidth-1:0] count_q, count_d;

  // Saturates at the limit so a disabled timeout never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LimitValue)) begin
      count_d = count_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TimeoutCycles != 0) && enable && (count_q == LimitValue);

endmodule

// File: rtl/pc_sequence_controller.sv
// Multicycle instruction sequencer owning the PC write enable and source select:
// boundary/IRQ sampling, fetch, decode, execute, PC update and exception entry.
module pc_sequence_controller
  import program_counter_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  output logic       fetchRequest,
  input  logic       fetchAck,
  input  logic       fetchFault,
  input  logic [4:0] fetchFaultCause,
  input  logic       fetchFaultUserTlbMiss,
  output logic       instructionRegisterWriteEnable,
  input  logic [2:0] instructionClass,
  input  logic       decodeFault,
  input  logic [4:0] decodeFaultCause,
  output logic       executeStart,
  input  logic       executeDone,
  input  logic       executeFault,
  input  logic [4:0] executeFaultCause,
  input  logic       executeFaultUserTlbMiss,
  input  logic       branchTaken,
  input  logic       pendingInterrupt,
  input  logic [3:0] interruptCause,
  output logic       pcWriteEnable,
  output logic [2:0] pcWriteDataSource,
  output logic       exceptionEnter,
  output logic [4:0] exceptionCause,
  output logic       exceptionPcAdjust,
  output logic       rfxEnter
);

  state_e       state_q, state_d;
  logic [4:0]   cause_q, cause_d;
  logic         user_tlb_q, user_tlb_d;
  logic         adjust_q, adjust_d;
  instr_class_e class_q, class_d;

  logic in_fetch;
  logic fetch_expired;

  assign in_fetch = (state_q == StFetch);

  fetch_timeout_counter #(
    .TimeoutCycles(FETCH_TIMEOUT_CYCLES)
  ) u_fetch_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_fetch),
    .enable (in_fetch),
    .expired(fetch_expired)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    user_tlb_d = user_tlb_q;
    adjust_d   = adjust_q;
    class_d    = class_q;

    fetchRequest                   = 1'b0;
    instructionRegisterWriteEnable = 1'b0;
    executeStart                   = 1'b0;
    pcWriteEnable                  = 1'b0;
    pcWriteDataSource              = 3'd0;
    exceptionEnter                 = 1'b0;
    exceptionCause                 = 5'd0;
    exceptionPcAdjust              = 1'b0;
    rfxEnter                       = 1'b0;

    unique case (state_q)
      StBoundary: begin
        if (pendingInterrupt) begin
          cause_d    = {1'b0, interruptCause};
          user_tlb_d = 1'b0;
          adjust_d   = 1'b0;
          state_d    = StException;
        end else begin
          state_d = StFetch;
        end
      end

      // Completion outputs here are Mealy on fetchAck so the PC advances in the ack cycle.
      StFetch: begin
        fetchRequest = 1'b1;
        if (fetchFault) begin
          cause_d    = fetchFaultCause;
          user_tlb_d = fetchFaultUserTlbMiss;
          adjust_d   = 1'b0;
          state_d    = StException;
        end else if (fetchAck) begin
          instructionRegisterWriteEnable = 1'b1;
          pcWriteEnable                  = 1'b1;
          pcWriteDataSource              = PcSrcIncrement;
          state_d                        = StDecode;
        end else if (fetch_expired) begin
          cause_d    = CauseBusTimeout;
          user_tlb_d = 1'b0;
          adjust_d   = 1'b0;
          state_d    = StException;
        end
      end

      // PC already points past this instruction, hence adjust=1 from here on.
      StDecode: begin
        if (decodeFault) begin
          cause_d    = decodeFaultCause;
          user_tlb_d = 1'b0;
          adjust_d   = 1'b1;
          state_d    = StException;
        end else if (instructionClass == ClassTrap) begin
          cause_d    = CauseTrap;
          user_tlb_d = 1'b0;
          adjust_d   = 1'b1;
          state_d    = StException;
        end else begin
          executeStart = 1'b1;
          state_d      = StExecute;
        end
      end

      StExecute: begin
        if (executeFault) begin
          cause_d    = executeFaultCause;
          user_tlb_d = executeFaultUserTlbMiss;
          adjust_d   = 1'b1;
          state_d    = StException;
        end else if (executeDone) begin
          class_d = instr_class_e'(instructionClass);
          state_d = StUpdate;
        end
      end

      StUpdate: begin
        case (class_q)
          ClassBranch: begin
            if (branchTaken) begin
              pcWriteEnable     = 1'b1;
              pcWriteDataSource = PcSrcAddImmediate;
            end
          end
          ClassJump: begin
            pcWriteEnable     = 1'b1;
            pcWriteDataSource = PcSrcAddOffset;
          end
          ClassJumpRegister: begin
            pcWriteEnable     = 1'b1;
            pcWriteDataSource = PcSrcExplicit;
          end
          ClassRfx: begin
            pcWriteEnable     = 1'b1;
            pcWriteDataSource = PcSrcExplicit;
            rfxEnter          = 1'b1;
          end
          default: ;
        endcase
        state_d = StBoundary;
      end

      StException: begin
        pcWriteEnable     = 1'b1;
        pcWriteDataSource = user_tlb_q ? PcSrcUserTlbMiss : PcSrcException;
        exceptionEnter    = 1'b1;
        exceptionCause    = cause_q;
        exceptionPcAdjust = adjust_q;
        state_d           = StBoundary;
      end

      default: state_d = StBoundary;
    endcase

    // Reset silences every output in the reset cycle itself, including a live fetch.
    if (reset) begin
      fetchRequest                   = 1'b0;
      instructionRegisterWriteEnable = 1'b0;
      executeStart                   = 1'b0;
      pcWriteEnable                  = 1'b0;
      pcWriteDataSource              = 3'd0;
      exceptionEnter                 = 1'b0;
      exceptionCause                 = 5'd0;
      exceptionPcAdjust              = 1'b0;
      rfxEnter                       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StBoundary;
      cause_q    <= 5'd0;
      user_tlb_q <= 1'b0;
      adjust_q   <= 1'b0;
      class_q    <= ClassOrdinary;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      user_tlb_q <= user_tlb_d;
      adjust_q   <= adjust_d;
      class_q    <= class_d;
    end
  end

endmodule

// File: tb/tb_pc_sequence_controller.sv
// Bench for pc_sequence_controller: directed and randomized instructions, each
// checked against per-instruction expectations derived from the sequencing rules.
module tb_pc_sequence_controller;
  import program_counter_pkg::*;

  localparam int unsigned TimeoutCycles = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       fetchRequest, fetchAck, fetchFault, fetchFaultUserTlbMiss;
  logic [4:0] fetchFaultCause;
  logic       instructionRegisterWriteEnable;
  logic [2:0] instructionClass;
  logic       decodeFault;
  logic [4:0] decodeFaultCause;
  logic       executeStart, executeDone, executeFault, executeFaultUserTlbMiss;
  logic [4:0] executeFaultCause;
  logic       branchTaken, pendingInterrupt;
  logic [3:0] interruptCause;
  logic       pcWriteEnable;
  logic [2:0] pcWriteDataSource;
  logic       exceptionEnter;
  logic [4:0] exceptionCause;
  logic       exceptionPcAdjust, rfxEnter;

  int asserts_made = 0;
  int failures     = 0;

  always #5 clock = ~clock;

  pc_sequence_controller #(
    .FETCH_TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .fetchRequest                  (fetchRequest),
    .fetchAck                      (fetchAck),
    .fetchFault                    (fetchFault),
    .fetchFaultCause               (fetchFaultCause),
    .fetchFaultUserTlbMiss         (fetchFaultUserTlbMiss),
    .instructionRegisterWriteEnable(instructionRegisterWriteEnable),
    .instructionClass              (instructionClass),
    .decodeFault                   (decodeFault),
    .decodeFaultCause              (decodeFaultCause),
    .executeStart                  (executeStart),
    .executeDone                   (executeDone),
    .executeFault                  (executeFault),
    .executeFaultCause             (executeFaultCause),
    .executeFaultUserTlbMiss       (executeFaultUserTlbMiss),
    .branchTaken                   (branchTaken),
    .pendingInterrupt              (pendingInterrupt),
    .interruptCause                (interruptCause),
    .pcWriteEnable                 (pcWriteEnable),
    .pcWriteDataSource             (pcWriteDataSource),
    .exceptionEnter                (exceptionEnter),
    .exceptionCause                (exceptionCause),
    .exceptionPcAdjust             (exceptionPcAdjust),
    .rfxEnter                      (rfxEnter)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    asserts_made++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({fetchRequest, instructionRegisterWriteEnable, executeStart, pcWriteEnable,
                pcWriteDataSource, exceptionEnter, exceptionCause, exceptionPcAdjust, rfxEnter});
  endfunction

  task automatic idle_inputs();
    fetchAck = 1'b0; fetchFault = 1'b0; fetchFaultCause = 5'd0; fetchFaultUserTlbMiss = 1'b0;
    instructionClass = 3'd0; decodeFault = 1'b0; decodeFaultCause = 5'd0;
    executeDone = 1'b0; executeFault = 1'b0; executeFaultCause = 5'd0;
    executeFaultUserTlbMiss = 1'b0; branchTaken = 1'b0;
    pendingInterrupt = 1'b0; interruptCause = 4'd0;
  endtask

  // Drives one instruction starting at a boundary cycle and checks its observable effect.
  // ack_at / fault_at are 0-based request-cycle indices; -1 means never.
  task automatic run_instr(input string tag, input bit irq, input logic [3:0] irqc,
                           input int ack_at, input int fault_at, input logic [4:0] fcause,
                           input bit fuser, input logic [2:0] cls, input bit dfault,
                           input logic [4:0] dcause, input int exec_at, input bit efault,
                           input logic [4:0] ecause, input bit euser, input bit taken);
    int cycle = 0, req_idx = 0, start_seen = -1, done_cycle = -1, first_req = -1;
    int req_count = 0, ir_count = 0, start_count = 0, rfx_count = 0, exc_count = 0;
    bit finished = 1'b0;
    logic [4:0] obs_cause = 5'd0;
    logic obs_adj = 1'b0;
    logic [2:0] obs_writes[$];
    logic [2:0] exp_writes[$];
    int exp_req = 0, exp_ir = 0, exp_start = 0, exp_rfx = 0, exp_exc = 1, exp_first = -1;
    logic [4:0] exp_cause = 5'd0;
    logic exp_adj = 1'b0;

    while (!finished && cycle < 200) begin
      @(negedge clock);
      idle_inputs();
      pendingInterrupt = irq && (cycle == 0);
      interruptCause = irqc;
      fetchFaultCause = fcause; fetchFaultUserTlbMiss = fuser;
      instructionClass = cls; decodeFault = dfault; decodeFaultCause = dcause;
      executeFaultCause = ecause; executeFaultUserTlbMiss = euser; branchTaken = taken;
      #1;
      if (fetchRequest) begin
        if (req_idx == fault_at) begin
          fetchFault = 1'b1;
          fetchAck = (ack_at == fault_at);
        end else if (req_idx == ack_at) begin
          fetchAck = 1'b1;
        end
      end
      if (start_seen >= 0 && cycle - start_seen == exec_at) begin
        executeDone = 1'b1;
        executeFault = efault;
      end
      #1;
      if (fetchRequest) begin
        if (first_req < 0) first_req = cycle;
        req_count++;
        req_idx++;
      end
      if (instructionRegisterWriteEnable) ir_count++;
      if (pcWriteEnable) begin
        obs_writes.push_back(pcWriteDataSource);
        if (pcWriteDataSource == PcSrcIncrement) check({tag, "_inc_on_ack"}, 32'(fetchAck), 32'd1);
      end else begin
        check({tag, "_src_idle"}, 32'(pcWriteDataSource), 32'd0);
      end
      if (executeStart) begin
        start_seen = cycle;
        start_count++;
      end
      if (rfxEnter) rfx_count++;
      if (exceptionEnter) begin
        exc_count++;
        obs_cause = exceptionCause;
        obs_adj = exceptionPcAdjust;
        finished = 1'b1;
      end
      if (executeDone && !executeFault) done_cycle = cycle;
      if (done_cycle >= 0 && cycle == done_cycle + 1) finished = 1'b1;
      cycle++;
    end
    check({tag, "_completed"}, 32'(finished), 32'd1);

    // Expected effect of the instruction, straight from the sequencing rules.
    if (irq) begin
      exp_writes.push_back(PcSrcException);
      exp_cause = {1'b0, irqc};
    end else begin
      exp_first = 1;
      if (fault_at >= 0) begin
        exp_req = fault_at + 1;
        exp_writes.push_back(fuser ? PcSrcUserTlbMiss : PcSrcException);
        exp_cause = fcause;
      end else if (ack_at < 0) begin
        exp_req = TimeoutCycles;
        exp_writes.push_back(PcSrcException);
        exp_cause = CauseBusTimeout;
      end else begin
        exp_req = ack_at + 1;
        exp_ir = 1;
        exp_writes.push_back(PcSrcIncrement);
        if (dfault || cls == ClassTrap) begin
          exp_writes.push_back(PcSrcException);
          exp_cause = dfault ? dcause : CauseTrap;
          exp_adj = 1'b1;
        end else begin
          exp_start = 1;
          if (efault) begin
            exp_writes.push_back(euser ? PcSrcUserTlbMiss : PcSrcException);
            exp_cause = ecause;
            exp_adj = 1'b1;
          end else begin
            exp_exc = 0;
            if (cls == ClassBranch && taken) exp_writes.push_back(PcSrcAddImmediate);
            if (cls == ClassJump) exp_writes.push_back(PcSrcAddOffset);
            if (cls == ClassJumpRegister || cls == ClassRfx) exp_writes.push_back(PcSrcExplicit);
            if (cls == ClassRfx) exp_rfx = 1;
          end
        end
      end
    end

    check({tag, "_req_cycles"}, 32'(req_count), 32'(exp_req));
    check({tag, "_first_req"}, 32'(first_req), 32'(exp_first));
    check({tag, "_ir_writes"}, 32'(ir_count), 32'(exp_ir));
    check({tag, "_exec_starts"}, 32'(start_count), 32'(exp_start));
    check({tag, "_rfx_pulses"}, 32'(rfx_count), 32'(exp_rfx));
    check({tag, "_exc_pulses"}, 32'(exc_count), 32'(exp_exc));
    if (exp_exc == 1) begin
      check({tag, "_exc_cause"}, 32'(obs_cause), 32'(exp_cause));
      check({tag, "_exc_adjust"}, 32'(obs_adj), 32'(exp_adj));
    end
    check({tag, "_pc_writes"}, 32'(obs_writes.size()), 32'(exp_writes.size()));
    for (int i = 0; i < obs_writes.size() && i < exp_writes.size(); i++) begin
      check({tag, "_pc_src"}, 32'(obs_writes[i]), 32'(exp_writes[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit irq, fuser, dfault, efault, euser, taken;
    logic [3:0] irqc;
    logic [4:0] fcause, dcause, ecause;
    logic [2:0] cls;
    int ack_at, fault_at, exec_at, outcome;

    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("reset_outputs", all_outputs(), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // tag, irq, irqc, ack, fault, fcause, fuser, class, dfault, dcause, exec, efault, ecause, euser, taken
    run_instr("ordinary", 0, 0, 3, -1, 0, 0, ClassOrdinary, 0, 0, 2, 0, 0, 0, 0);
    run_instr("br_taken", 0, 0, 1, -1, 0, 0, ClassBranch, 0, 0, 1, 0, 0, 0, 1);
    run_instr("br_not", 0, 0, 0, -1, 0, 0, ClassBranch, 0, 0, 3, 0, 0, 0, 0);
    run_instr("irq5", 1, 4'd5, 0, -1, 0, 0, ClassOrdinary, 0, 0, 1, 0, 0, 0, 0);
    run_instr("fetch_fault", 0, 0, 1, 1, CauseTlbMiss, 1, ClassOrdinary, 0, 0, 1, 0, 0, 0, 0);
    run_instr("timeout", 0, 0, -1, -1, 0, 0, ClassOrdinary, 0, 0, 1, 0, 0, 0, 0);
    run_instr("ack_at_limit", 0, 0, 3, -1, 0, 0, ClassJump, 0, 0, 1, 0, 0, 0, 0);
    run_instr("rfx", 0, 0, 2, -1, 0, 0, ClassRfx, 0, 0, 2, 0, 0, 0, 0);
    run_instr("jr", 0, 0, 0, -1, 0, 0, ClassJumpRegister, 0, 0, 1, 0, 0, 0, 0);
    run_instr("trap", 0, 0, 0, -1, 0, 0, ClassTrap, 0, 0, 1, 0, 0, 0, 0);
    run_instr("illegal", 0, 0, 1, -1, 0, 0, ClassJump, 1, CauseIllegalInstr, 1, 0, 0, 0, 0);
    run_instr("exec_fault", 0, 0, 0, -1, 0, 0, ClassJump, 0, 0, 2, 1, CauseTlbMiss, 1, 0);

    // RFX interrupted by reset while executing.
    @(negedge clock); idle_inputs(); instructionClass = ClassRfx; #1;
    @(negedge clock); fetchAck = 1'b1; #1;
    check("rst_run_inc", 32'(pcWriteEnable), 32'd1);
    @(negedge clock); fetchAck = 1'b0; #1;
    check("rst_run_start", 32'(executeStart), 32'd1);
    @(negedge clock); #1;
    @(negedge clock); reset = 1'b1; #1;
    check("rst_mid_exec_outputs", all_outputs(), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); #1;
    check("rst_boundary_outputs", all_outputs(), 32'd0);
    @(negedge clock); #1;
    check("rst_refetch", 32'(fetchRequest), 32'd1);
    reset = 1'b1; #1;
    check("rst_drops_fetch", 32'(fetchRequest), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    run_instr("after_reset", 0, 0, 1, -1, 0, 0, ClassRfx, 0, 0, 1, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      irq = ($urandom_range(0, 5) == 0);
      irqc = 4'($urandom);
      outcome = $urandom_range(0, 5);
      fault_at = (outcome == 0) ? $urandom_range(0, TimeoutCycles - 1) : -1;
      if (outcome == 0) ack_at = ($urandom_range(0, 1) == 1) ? fault_at : -1;
      else if (outcome == 1) ack_at = -1;
      else ack_at = $urandom_range(0, TimeoutCycles - 1);
      fcause = 5'($urandom); fuser = 1'($urandom);
      cls = 3'($urandom_range(0, 5));
      dfault = ($urandom_range(0, 7) == 0); dcause = 5'($urandom);
      exec_at = $urandom_range(1, 4);
      efault = ($urandom_range(0, 5) == 0); ecause = 5'($urandom); euser = 1'($urandom);
      taken = 1'($urandom);
      run_instr("rand", irq, irqc, ack_at, fault_at, fcause, fuser, cls, dfault, dcause,
                exec_at, efault, ecause, euser, taken);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_made, failures);
    $finish;
  end

endmodule
